wb_stage: RTL

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage.sv | 136 +++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// Write-back merge stage: ALU results and load results share one register-file
// write port; loads wait in a 2-entry FIFO, and the currently presented write is forwarded.
module wb_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    input  logic [4:0]       alu_rd,
    input  logic [WIDTH-1:0] alu_data,
    input  logic             mem_valid,
    input  logic [4:0]       mem_rd,
    input  logic [WIDTH-1:0] mem_data,
    output logic             mem_ready,
    output logic [4:0]       rd,
    output logic [WIDTH-1:0] data,
    input  logic [4:0]       q0,
    input  logic [4:0]       q1,
    output logic             fwd0_hit,
    output logic             fwd1_hit,
    output logic [WIDTH-1:0] fwd0_val,
    output logic [WIDTH-1:0] fwd1_val
);

    localparam logic [4:0] R_ZERO = 5'd0;

    logic             ent_vld  [2];
    logic [4:0]       ent_rd   [2];
    logic [WIDTH-1:0] ent_data [2];
    logic             head;
    logic             tail;
    logic [1:0]       count;

    logic             alu_wr;
    logic             mem_keep;
    logic             nx;
    logic             occ0;
    logic             occ1;
    logic             live0;
    logic             live1;
    logic             fifo_wr;
    logic             fifo_sel;
    logic [1:0]       pops;
    logic             push;
    logic             bypass;
    logic [4:0]       wr_rd;
    logic [WIDTH-1:0] wr_data;

    always_comb begin
        alu_wr    = alu_valid && (alu_rd != R_ZERO);
        mem_ready = (count != 2'd2);
        // A load racing an ALU write to the same register is already stale.
        mem_keep  = mem_valid && mem_ready && (mem_rd != R_ZERO)
                    && !(alu_wr && (mem_rd == alu_rd));

        nx    = ~head;
        occ0  = (count != 2'd0);
        occ1  = (count == 2'd2);
        live0 = occ0 && ent_vld[head] && !(alu_wr && (ent_rd[head] == alu_rd));
        live1 = occ1 && ent_vld[nx]   && !(alu_wr && (ent_rd[nx]   == alu_rd));

        fifo_wr  = 1'b0;
        fifo_sel = head;
        pops     = 2'd0;
        // Dead entries are popped for free, so they never take the write slot.
        if (alu_wr) begin
            if (!live0)
                pops = occ1 ? (live1 ? 2'd1 : 2'd2) : (occ0 ? 2'd1 : 2'd0);
        end else if (live0) begin
            fifo_wr = 1'b1;
            pops    = (occ1 && !live1) ? 2'd2 : 2'd1;
        end else if (live1) begin
            fifo_wr  = 1'b1;
            fifo_sel = nx;
            pops     = 2'd2;
        end else begin
            pops = count;
        end

        push   = mem_keep && (alu_wr || fifo_wr);
        bypass = mem_keep && !alu_wr && !fifo_wr;

        wr_rd   = R_ZERO;
        wr_data = data;
        if (alu_wr) begin
            wr_rd   = alu_rd;
            wr_data = alu_data;
        end else if (fifo_wr) begin
            wr_rd   = ent_rd[fifo_sel];
            wr_data = ent_data[fifo_sel];
        end else if (bypass) begin
            wr_rd   = mem_rd;
            wr_data = mem_data;
        end
    end

    // Register-file write port and FIFO control update at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd    <= R_ZERO;
            data  <= '0;
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
            for (int i = 0; i < 2; i++)
                ent_vld[i] <= 1'b0;
        end else begin
            rd    <= wr_rd;
            data  <= wr_data;
            head  <= head ^ pops[0];
            tail  <= tail ^ push;
            count <= count - pops + {1'b0, push};
            for (int i = 0; i < 2; i++) begin
                if (alu_wr && (ent_rd[i] == alu_rd))
                    ent_vld[i] <= 1'b0;
                if (push && (tail == 1'(i)))
                    ent_vld[i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ent_rd[tail]   <= mem_rd;
            ent_data[tail] <= mem_data;
        end
    end

    always_comb begin
        fwd0_hit = (q0 == rd) && (rd != R_ZERO);
        fwd1_hit = (q1 == rd) && (rd != R_ZERO);
        fwd0_val = fwd0_hit ? data : '0;
        fwd1_val = fwd1_hit ? data : '0;
    end

endmodule
